// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer definitions: sizes, ID width and the entry layout.
// Reservation stations and the register file take their ROB ID width from here.
package reorder_buffer_pkg;

    localparam int ROB_SIZE = 16;
    localparam int ROB_ID_W = 4;
    localparam int XLEN     = 32;
    localparam int RD_W     = 5;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [ROB_ID_W:0] ROB_FULL_CNT = 5'd16;
    localparam logic [ROB_ID_W:0] CNT_ONE      = 5'd1;
    localparam logic [XLEN-1:0]   PC_STEP      = 32'd4;
    localparam logic [RD_W-1:0]   RD_ZERO      = 5'd0;

    typedef logic [ROB_ID_W-1:0] rob_id_t;

    typedef struct packed {
        logic            busy;
        logic            ready;
        logic [XLEN-1:0] pc;
        logic            has_rd;
        logic [RD_W-1:0] rd;
        logic            is_branch;
        logic            pred_taken;
        logic [XLEN-1:0] value;
        logic            taken;
        logic [XLEN-1:0] target;
    } rob_entry_t;

    // Pointer increment; ROB_SIZE is a power of two so wrap is free.
    function automatic rob_id_t next_ptr(input rob_id_t ptr);
        return ptr + 4'd1;
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Decode, ALU, update-bus, commit and roll-back signals of the reorder buffer.
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic                id_valid;
    logic [XLEN-1:0]     id_inst_pc;
    logic                id_has_rd;
    logic [RD_W-1:0]     id_rd;
    logic                id_is_branch;
    logic                id_pred_taken;
    rob_id_t             new_id;
    logic                rob_full;

    logic                alu_valid;
    rob_id_t             alu_rob_id;
    logic [XLEN-1:0]     alu_value;
    logic                alu_taken;
    logic [XLEN-1:0]     alu_target;

    logic                upd_valid;
    rob_id_t             upd_rob_id;
    logic [XLEN-1:0]     upd_value;

    logic                cm_valid;
    logic [RD_W-1:0]     cm_rd;
    logic [XLEN-1:0]     cm_value;
    rob_id_t             cm_rob_id;

    logic                roll_back_flag;
    logic [XLEN-1:0]     roll_back_pc;

    modport master (
        input  id_valid, id_inst_pc, id_has_rd, id_rd, id_is_branch, id_pred_taken,
        input  alu_valid, alu_rob_id, alu_value, alu_taken, alu_target,
        output new_id, rob_full,
        output upd_valid, upd_rob_id, upd_value,
        output cm_valid, cm_rd, cm_value, cm_rob_id,
        output roll_back_flag, roll_back_pc
    );

    modport slave (
        output id_valid, id_inst_pc, id_has_rd, id_rd, id_is_branch, id_pred_taken,
        output alu_valid, alu_rob_id, alu_value, alu_taken, alu_target,
        input  new_id, rob_full,
        input  upd_valid, upd_rob_id, upd_value,
        input  cm_valid, cm_rd, cm_value, cm_rob_id,
        input  roll_back_flag, roll_back_pc
    );

endinterface

// File: rtl/reorder_buffer_chk.sv
// Protocol checker: the ALU may only complete an entry that is still in flight.
module reorder_buffer_chk
    import reorder_buffer_pkg::*;
(
    input logic                clk,
    input logic                rst,
    input logic                rdy,
    input logic                alu_valid,
    input rob_id_t             alu_rob_id,
    input logic                roll_back_flag,
    input logic [ROB_SIZE-1:0] busy_vec
);

    // Completions during a flush cycle are dropped, so they are not checked.
    alu_id_busy: assert property (@(posedge clk) disable iff (rst)
        (rdy && alu_valid && !roll_back_flag) |-> busy_vec[alu_rob_id]);

endmodule

// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer: in-order allocate/commit, out-of-order
// completion with a one-cycle update broadcast, and flush on branch mispredict.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input logic             clk,
    input logic             rst,
    input logic             rdy,
    reorder_buffer_if.master rob
);

    rob_entry_t          entries_r [ROB_SIZE];
    rob_id_t             head_r;
    rob_id_t             tail_r;
    logic [ROB_ID_W:0]   count_r;

    logic                upd_valid_r;
    rob_id_t             upd_rob_id_r;
    logic [XLEN-1:0]     upd_value_r;
    logic                cm_valid_r;
    logic [RD_W-1:0]     cm_rd_r;
    logic [XLEN-1:0]     cm_value_r;
    rob_id_t             cm_rob_id_r;
    logic                roll_back_flag_r;
    logic [XLEN-1:0]     roll_back_pc_r;

    rob_entry_t          head_entry_s;
    logic                rob_full_s;
    logic                accept_s;
    logic                alloc_s;
    logic                comp_s;
    logic                commit_s;
    logic                mispredict_s;
    logic                write_rd_s;
    logic [XLEN-1:0]     rb_pc_s;
    logic [ROB_ID_W:0]   count_nxt_s;
    logic [ROB_SIZE-1:0] busy_vec_s;

    assign rob_full_s         = (count_r == ROB_FULL_CNT);
    assign rob.rob_full       = rob_full_s;
    assign rob.new_id         = tail_r;
    assign rob.upd_valid      = upd_valid_r;
    assign rob.upd_rob_id     = upd_rob_id_r;
    assign rob.upd_value      = upd_value_r;
    assign rob.cm_valid       = cm_valid_r;
    assign rob.cm_rd          = cm_rd_r;
    assign rob.cm_value       = cm_value_r;
    assign rob.cm_rob_id      = cm_rob_id_r;
    assign rob.roll_back_flag = roll_back_flag_r;
    assign rob.roll_back_pc   = roll_back_pc_r;

    // Per-cycle decisions: allocate, complete, commit and mispredict detection.
    always_comb begin
        head_entry_s = entries_r[head_r];
        accept_s     = rdy & ~roll_back_flag_r;
        alloc_s      = FALSE;
        comp_s       = FALSE;
        commit_s     = FALSE;
        mispredict_s = FALSE;
        write_rd_s   = FALSE;
        rb_pc_s      = head_entry_s.pc + PC_STEP;
        if (accept_s) begin
            alloc_s = rob.id_valid & ~rob_full_s;
            comp_s  = rob.alu_valid & entries_r[rob.alu_rob_id].busy;
        end else begin
            alloc_s = FALSE;
            comp_s  = FALSE;
        end
        // Commit looks at the registered ready bit, so a same-cycle completion waits one cycle.
        if (rdy && head_entry_s.busy && head_entry_s.ready) begin
            commit_s     = TRUE;
            mispredict_s = head_entry_s.is_branch & (head_entry_s.taken != head_entry_s.pred_taken);
            write_rd_s   = head_entry_s.has_rd & (head_entry_s.rd != RD_ZERO);
        end else begin
            commit_s     = FALSE;
            mispredict_s = FALSE;
            write_rd_s   = FALSE;
        end
        if (head_entry_s.taken) begin
            rb_pc_s = head_entry_s.target;
        end else begin
            rb_pc_s = head_entry_s.pc + PC_STEP;
        end
    end

    // Occupancy update from allocate/commit.
    always_comb begin
        count_nxt_s = count_r;
        case ({alloc_s, commit_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Busy vector for the protocol checker.
    always_comb begin
        busy_vec_s = '0;
        for (int i = 0; i < ROB_SIZE; i++) begin
            busy_vec_s[i] = entries_r[i].busy;
        end
    end

    // Entry array, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries_r[i] <= '0;
            end
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else if (mispredict_s) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries_r[i].busy  <= FALSE;
                entries_r[i].ready <= FALSE;
            end
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else if (rdy) begin
            if (alloc_s) begin
                entries_r[tail_r] <= '{busy: TRUE, ready: FALSE, pc: rob.id_inst_pc,
                                       has_rd: rob.id_has_rd, rd: rob.id_rd,
                                       is_branch: rob.id_is_branch, pred_taken: rob.id_pred_taken,
                                       value: '0, taken: FALSE, target: '0};
                tail_r <= next_ptr(tail_r);
            end
            if (comp_s) begin
                entries_r[rob.alu_rob_id].ready  <= TRUE;
                entries_r[rob.alu_rob_id].value  <= rob.alu_value;
                entries_r[rob.alu_rob_id].taken  <= rob.alu_taken;
                entries_r[rob.alu_rob_id].target <= rob.alu_target;
            end
            if (commit_s) begin
                entries_r[head_r].busy <= FALSE;
                head_r <= next_ptr(head_r);
            end
            count_r <= count_nxt_s;
        end
    end

    // Registered pulse and data outputs; pulses drop whenever rdy is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            upd_valid_r      <= FALSE;
            upd_rob_id_r     <= '0;
            upd_value_r      <= '0;
            cm_valid_r       <= FALSE;
            cm_rd_r          <= '0;
            cm_value_r       <= '0;
            cm_rob_id_r      <= '0;
            roll_back_flag_r <= FALSE;
            roll_back_pc_r   <= '0;
        end else if (!rdy) begin
            upd_valid_r      <= FALSE;
            cm_valid_r       <= FALSE;
            roll_back_flag_r <= FALSE;
        end else begin
            // A completion landing on the flush edge is discarded, so nothing is broadcast.
            upd_valid_r      <= comp_s & ~mispredict_s;
            cm_valid_r       <= write_rd_s;
            roll_back_flag_r <= mispredict_s;
            if (comp_s && !mispredict_s) begin
                upd_rob_id_r <= rob.alu_rob_id;
                upd_value_r  <= rob.alu_value;
            end
            if (write_rd_s) begin
                cm_rd_r     <= head_entry_s.rd;
                cm_value_r  <= head_entry_s.value;
                cm_rob_id_r <= head_r;
            end
            if (mispredict_s) begin
                roll_back_pc_r <= rb_pc_s;
            end
        end
    end

    reorder_buffer_chk u_chk (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .alu_valid      (rob.alu_valid),
        .alu_rob_id     (rob.alu_rob_id),
        .roll_back_flag (roll_back_flag_r),
        .busy_vec       (busy_vec_s)
    );

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer with hand-computed expectations.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic clk;
    logic rst;
    logic rdy;
    int   pass_cnt;
    int   total_cnt;

    reorder_buffer_if rif ();

    reorder_buffer dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .rob (rif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rdy               = 1'b1;
        rif.id_valid      = 1'b0;
        rif.id_inst_pc    = 32'd0;
        rif.id_has_rd     = 1'b0;
        rif.id_rd         = 5'd0;
        rif.id_is_branch  = 1'b0;
        rif.id_pred_taken = 1'b0;
        rif.alu_valid     = 1'b0;
        rif.alu_rob_id    = 4'd0;
        rif.alu_value     = 32'd0;
        rif.alu_taken     = 1'b0;
        rif.alu_target    = 32'd0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic alloc(input logic [31:0] pc, input logic has_rd, input logic [4:0] rd,
                         input logic br, input logic pt);
        rif.id_valid      = 1'b1;
        rif.id_inst_pc    = pc;
        rif.id_has_rd     = has_rd;
        rif.id_rd         = rd;
        rif.id_is_branch  = br;
        rif.id_pred_taken = pt;
        step();
        rif.id_valid      = 1'b0;
    endtask

    task automatic complete(input logic [3:0] id, input logic [31:0] val,
                            input logic tk, input logic [31:0] tgt);
        rif.alu_valid  = 1'b1;
        rif.alu_rob_id = id;
        rif.alu_value  = val;
        rif.alu_taken  = tk;
        rif.alu_target = tgt;
        step();
        rif.alu_valid  = 1'b0;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b1;

        // Reset state
        do_reset();
        check("rst_new_id", 32'(rif.new_id), 32'd0);
        check("rst_full", 32'(rif.rob_full), 32'd0);
        check("rst_upd_valid", 32'(rif.upd_valid), 32'd0);
        check("rst_cm_valid", 32'(rif.cm_valid), 32'd0);
        check("rst_rb_flag", 32'(rif.roll_back_flag), 32'd0);
        check("rst_cm_value", rif.cm_value, 32'd0);
        check("rst_count", 32'(dut.count_r), 32'd0);

        // Allocate three register-writing instructions
        for (int i = 0; i < 3; i++) begin
            check("alloc_new_id", 32'(rif.new_id), 32'(i));
            alloc(32'(i * 4), 1'b1, 5'(i + 1), 1'b0, 1'b0);
            check("alloc_no_cm", 32'(rif.cm_valid), 32'd0);
        end
        check("alloc3_full", 32'(rif.rob_full), 32'd0);
        check("alloc3_new_id", 32'(rif.new_id), 32'd3);

        // Out-of-order completion: id1 before id0
        complete(4'd1, 32'h55, 1'b0, 32'd0);
        check("ooo_upd_valid", 32'(rif.upd_valid), 32'd1);
        check("ooo_upd_id", 32'(rif.upd_rob_id), 32'd1);
        check("ooo_upd_value", rif.upd_value, 32'h55);
        check("ooo_no_commit", 32'(rif.cm_valid), 32'd0);
        step();
        check("upd_pulse_drop", 32'(rif.upd_valid), 32'd0);
        check("ooo_still_no_commit", 32'(rif.cm_valid), 32'd0);
        complete(4'd0, 32'h11, 1'b0, 32'd0);
        check("id0_upd_id", 32'(rif.upd_rob_id), 32'd0);
        check("id0_same_cycle_no_commit", 32'(rif.cm_valid), 32'd0);
        step();
        check("cm0_valid", 32'(rif.cm_valid), 32'd1);
        check("cm0_rd", 32'(rif.cm_rd), 32'd1);
        check("cm0_value", rif.cm_value, 32'h11);
        check("cm0_rob_id", 32'(rif.cm_rob_id), 32'd0);
        step();
        check("cm1_valid", 32'(rif.cm_valid), 32'd1);
        check("cm1_rd", 32'(rif.cm_rd), 32'd2);
        check("cm1_value", rif.cm_value, 32'h55);
        check("cm1_rob_id", 32'(rif.cm_rob_id), 32'd1);
        step();
        check("cm_idle", 32'(rif.cm_valid), 32'd0);

        // Fill all 16 entries, then a 17th request is ignored
        do_reset();
        for (int i = 0; i < 16; i++) begin
            alloc(32'h1000 + 32'(i * 4), 1'b1, 5'd5, 1'b0, 1'b0);
        end
        check("fill_full", 32'(rif.rob_full), 32'd1);
        check("fill_new_id_wrap", 32'(rif.new_id), 32'd0);
        check("fill_count", 32'(dut.count_r), 32'd16);
        alloc(32'h2000, 1'b1, 5'd9, 1'b0, 1'b0);
        check("over_count", 32'(dut.count_r), 32'd16);
        check("over_new_id", 32'(rif.new_id), 32'd0);
        complete(4'd0, 32'h99, 1'b0, 32'd0);
        check("full_before_commit", 32'(rif.rob_full), 32'd1);
        step();
        check("full_cm_valid", 32'(rif.cm_valid), 32'd1);
        check("full_cm_rd", 32'(rif.cm_rd), 32'd5);
        check("full_cm_value", rif.cm_value, 32'h99);
        check("full_cm_rob_id", 32'(rif.cm_rob_id), 32'd0);
        check("full_drops", 32'(rif.rob_full), 32'd0);
        check("wrap_new_id", 32'(rif.new_id), 32'd0);
        alloc(32'h3000, 1'b1, 5'd5, 1'b0, 1'b0);
        check("refill_full", 32'(rif.rob_full), 32'd1);
        check("refill_new_id", 32'(rif.new_id), 32'd1);

        // Mispredicted branch (pred not-taken, actually taken) with three younger entries
        do_reset();
        alloc(32'h100, 1'b0, 5'd0, 1'b1, 1'b0);
        alloc(32'h104, 1'b1, 5'd6, 1'b0, 1'b0);
        alloc(32'h108, 1'b1, 5'd7, 1'b0, 1'b0);
        alloc(32'h10C, 1'b1, 5'd8, 1'b0, 1'b0);
        check("br_count", 32'(dut.count_r), 32'd4);
        complete(4'd2, 32'h77, 1'b0, 32'd0);
        complete(4'd0, 32'd0, 1'b1, 32'h200);
        check("br_no_rb_yet", 32'(rif.roll_back_flag), 32'd0);
        step();
        check("rb_flag", 32'(rif.roll_back_flag), 32'd1);
        check("rb_pc", rif.roll_back_pc, 32'h200);
        check("rb_count", 32'(dut.count_r), 32'd0);
        check("rb_new_id", 32'(rif.new_id), 32'd0);
        check("rb_no_cm", 32'(rif.cm_valid), 32'd0);
        alloc(32'h900, 1'b1, 5'd4, 1'b0, 1'b0);
        check("rb_pulse_drop", 32'(rif.roll_back_flag), 32'd0);
        check("rb_alloc_ignored", 32'(dut.count_r), 32'd0);
        check("post_rb_new_id", 32'(rif.new_id), 32'd0);
        alloc(32'h110, 1'b1, 5'd6, 1'b0, 1'b0);
        check("post_rb_count", 32'(dut.count_r), 32'd1);

        // Correctly predicted branch, then predicted-taken branch that falls through
        do_reset();
        alloc(32'h300, 1'b0, 5'd0, 1'b1, 1'b1);
        complete(4'd0, 32'd0, 1'b1, 32'h400);
        step();
        check("okbr_no_cm", 32'(rif.cm_valid), 32'd0);
        check("okbr_no_rb", 32'(rif.roll_back_flag), 32'd0);
        check("okbr_count", 32'(dut.count_r), 32'd0);
        check("okbr_new_id", 32'(rif.new_id), 32'd1);
        alloc(32'h500, 1'b0, 5'd0, 1'b1, 1'b1);
        complete(4'd1, 32'd0, 1'b0, 32'h700);
        step();
        check("nt_rb_flag", 32'(rif.roll_back_flag), 32'd1);
        check("nt_rb_pc", rif.roll_back_pc, 32'h504);
        step();
        check("nt_rb_drop", 32'(rif.roll_back_flag), 32'd0);

        // Simultaneous allocate and commit at count 5, then a 3-cycle freeze
        do_reset();
        for (int i = 0; i < 5; i++) begin
            alloc(32'h40 + 32'(i * 4), 1'b1, 5'(i + 1), 1'b0, 1'b0);
        end
        complete(4'd0, 32'hA, 1'b0, 32'd0);
        alloc(32'h600, 1'b1, 5'd6, 1'b0, 1'b0);
        check("simul_cm_valid", 32'(rif.cm_valid), 32'd1);
        check("simul_cm_rd", 32'(rif.cm_rd), 32'd1);
        check("simul_count", 32'(dut.count_r), 32'd5);
        check("simul_new_id", 32'(rif.new_id), 32'd6);
        complete(4'd1, 32'hB, 1'b0, 32'd0);
        check("pre_frz_upd", 32'(rif.upd_valid), 32'd1);
        check("pre_frz_no_cm", 32'(rif.cm_valid), 32'd0);
        rdy          = 1'b0;
        rif.id_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("frz_upd", 32'(rif.upd_valid), 32'd0);
            check("frz_cm", 32'(rif.cm_valid), 32'd0);
            check("frz_rb", 32'(rif.roll_back_flag), 32'd0);
            check("frz_count", 32'(dut.count_r), 32'd5);
            check("frz_new_id", 32'(rif.new_id), 32'd6);
        end
        rdy          = 1'b1;
        rif.id_valid = 1'b0;
        step();
        check("thaw_cm_valid", 32'(rif.cm_valid), 32'd1);
        check("thaw_cm_rd", 32'(rif.cm_rd), 32'd2);
        check("thaw_cm_value", rif.cm_value, 32'hB);
        check("thaw_count", 32'(dut.count_r), 32'd4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
